// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and sizing for the instruction fetch queue.
//   XLEN / WORD_SIZE : datapath widths of PC and instruction word
//   FQ_DEPTH         : default queue depth
//   FQ_PTR_W         : pointer width for the default depth
//   fetch_entry_t    : one queued fetch record {PC, PC+4, Instr}
package instr_fetch_queue_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned WORD_SIZE = 32;

  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]      PC;
    logic [XLEN-1:0]      PCp4;
    logic [WORD_SIZE-1:0] Instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode bus carried by the instruction fetch queue.
//   I side : PC_I, PCp4_I, Instr_I, ValidInstruction_I in; QueueFull_I out (StallPC)
//   control: FlushF (redirect), StallD (decode not accepting)
//   D side : PC_D, PCp4_D, Instr_D, ValidInstruction_D, Occupancy out
// slave is the queue itself; master is the surrounding pipeline.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) ();

  logic [XLEN-1:0]        PC_I;
  logic [XLEN-1:0]        PCp4_I;
  logic [WORD_SIZE-1:0]   Instr_I;
  logic                   ValidInstruction_I;
  logic                   QueueFull_I;
  logic                   FlushF;
  logic                   StallD;
  logic [XLEN-1:0]        PC_D;
  logic [XLEN-1:0]        PCp4_D;
  logic [WORD_SIZE-1:0]   Instr_D;
  logic                   ValidInstruction_D;
  logic [$clog2(DEPTH):0] Occupancy;

  modport slave (
    input  PC_I,
    input  PCp4_I,
    input  Instr_I,
    input  ValidInstruction_I,
    input  FlushF,
    input  StallD,
    output QueueFull_I,
    output PC_D,
    output PCp4_D,
    output Instr_D,
    output ValidInstruction_D,
    output Occupancy
  );

  modport master (
    output PC_I,
    output PCp4_I,
    output Instr_I,
    output ValidInstruction_I,
    output FlushF,
    output StallD,
    input  QueueFull_I,
    input  PC_D,
    input  PCp4_D,
    input  Instr_D,
    input  ValidInstruction_D,
    input  Occupancy
  );

endinterface

// File: rtl/instr_fetch_queue.sv
// Decoupling queue between instruction fetch and decode.
//   clk   : clock, all state updates on posedge
//   reset : asynchronous, active-low
//   fq    : fetch/decode bus (slave side); see instr_fetch_queue_if
// Each accepted fetch {PC, PC+4, Instr} is written at the tail; the head entry
// is shown to decode combinationally (show-ahead). QueueFull_I back-pressures
// the PC, FlushF drops every entry and the instruction on the I ports.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_queue_if.slave fq
);

  localparam int unsigned     PtrW      = $clog2(DEPTH);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

  fetch_entry_t    entry [DEPTH];
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic full;
  logic not_empty;
  logic enq;
  logic deq;
  logic valid_d;

  // Full depends on the registered count only, never on StallD.
  assign full      = (count_q == CountFull);
  assign not_empty = (count_q != '0);

  // Flush wins over both enqueue and dequeue.
  assign enq = fq.ValidInstruction_I & ~full & ~fq.FlushF;
  assign deq = not_empty & ~fq.StallD & ~fq.FlushF;

  assign wr_entry.PC    = fq.PC_I;
  assign wr_entry.PCp4  = fq.PCp4_I;
  assign wr_entry.Instr = fq.Instr_I;

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (fq.FlushF) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + 1'b1;
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry[tail_q] <= wr_entry;
    end
  end

  assign head_entry = entry[head_q];
  assign valid_d    = not_empty & ~fq.FlushF;

  // Data outputs are zeroed when nothing valid is presented, keeping traces clean.
  always_comb begin
    fq.ValidInstruction_D = valid_d;
    fq.PC_D               = '0;
    fq.PCp4_D             = '0;
    fq.Instr_D            = '0;
    if (valid_d) begin
      fq.PC_D    = head_entry.PC;
      fq.PCp4_D  = head_entry.PCp4;
      fq.Instr_D = head_entry.Instr;
    end
  end

  assign fq.QueueFull_I = full;
  assign fq.Occupancy   = count_q;

`ifdef ASSERT
  full_never_enq_a: assert property (@(posedge clk) disable iff (!reset) !(full && enq));
  count_bound_a:    assert property (@(posedge clk) disable iff (!reset) count_q <= CountFull);
`endif

endmodule
